reg_rename_file: RTL and testbench

- Architectural register file with per-register rename tags, sitting between decode/ROB issue and ROB commit.
- At issue: supplies operand values, or the producing ROB tag, for rs1/rs2.
- Records the new producer tag for rd.
- At commit: writes the committed value and clears the pending state only if the tag still matches.

---
 rtl/reg_rename_file.sv | 113 +++++++++++
 tb/tb_reg_rename_file.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_rename_file.sv
// Architectural register file with per-register ROB rename tags.
// Optional macro REG_COMMIT_BYPASS_EN forwards a clearing commit to same-cycle reads.
module reg_rename_file #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned ROB_IDX_W = 4,
  parameter int unsigned NREG      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_rdy,
  input  logic                 i_flush,
  input  logic                 i_issue_en,
  input  logic [4:0]           i_issue_rd,
  input  logic [ROB_IDX_W-1:0] i_issue_tag,
  input  logic                 i_commit_en,
  input  logic [4:0]           i_commit_rd,
  input  logic [ROB_IDX_W-1:0] i_commit_tag,
  input  logic [XLEN-1:0]      i_commit_val,
  input  logic [4:0]           i_rs1_addr,
  input  logic [4:0]           i_rs2_addr,
  output logic                 o_rs1_ready,
  output logic [XLEN-1:0]      o_rs1_val,
  output logic                 o_rs2_ready,
  output logic [XLEN-1:0]      o_rs2_val,
  output logic [5:0]           o_busy_cnt
);

  logic [XLEN-1:0]      r_val [NREG];
  logic [ROB_IDX_W-1:0] r_tag [NREG];
  logic [NREG-1:0]      r_busy;
  logic [5:0]           r_busy_cnt;

  logic                 w_commit_wr;
  logic                 w_commit_clr;
  logic                 w_issue_wr;
  logic [NREG-1:0]      w_busy_d;
  logic [5:0]           w_busy_cnt_d;

  assign w_commit_wr  = i_commit_en && (i_commit_rd != 5'd0);
  assign w_commit_clr = w_commit_wr && r_busy[i_commit_rd] &&
                        (r_tag[i_commit_rd] == i_commit_tag);
  assign w_issue_wr   = i_issue_en && (i_issue_rd != 5'd0) && !i_flush;

  // Issue is applied after commit so a same-cycle issue to the same rd wins.
  always_comb begin
    w_busy_d = r_busy;
    if (w_commit_clr) begin
      w_busy_d[i_commit_rd] = 1'b0;
    end
    if (w_issue_wr) begin
      w_busy_d[i_issue_rd] = 1'b1;
    end
    if (i_flush) begin
      w_busy_d = '0;
    end
    w_busy_d[0] = 1'b0;
  end

  always_comb begin
    w_busy_cnt_d = 6'd0;
    for (int i = 0; i < NREG; i++) begin
      w_busy_cnt_d = w_busy_cnt_d + 6'(w_busy_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_val[i] <= '0;
        r_tag[i] <= '0;
      end
      r_busy     <= '0;
      r_busy_cnt <= 6'd0;
    end else if (i_rdy) begin
      if (w_commit_wr) begin
        r_val[i_commit_rd] <= i_commit_val;
      end
      if (w_issue_wr) begin
        r_tag[i_issue_rd] <= i_issue_tag;
      end
      r_busy     <= w_busy_d;
      r_busy_cnt <= w_busy_cnt_d;
    end
  end

  function automatic logic [XLEN:0] read_port(input logic [4:0] addr);
    logic [XLEN:0] res;
    if (addr == 5'd0) begin
      res = {1'b1, {XLEN{1'b0}}};
    end else if (!r_busy[addr]) begin
      res = {1'b1, r_val[addr]};
`ifdef REG_COMMIT_BYPASS_EN
    end else if (i_rdy && w_commit_clr && (addr == i_commit_rd)) begin
      res = {1'b1, i_commit_val};
`endif
    end else begin
      res = {1'b0, {(XLEN - ROB_IDX_W){1'b0}}, r_tag[addr]};
    end
    return res;
  endfunction

  logic [XLEN:0] w_rs1;
  logic [XLEN:0] w_rs2;

  assign w_rs1       = read_port(i_rs1_addr);
  assign w_rs2       = read_port(i_rs2_addr);
  assign o_rs1_ready = w_rs1[XLEN];
  assign o_rs1_val   = w_rs1[XLEN-1:0];
  assign o_rs2_ready = w_rs2[XLEN];
  assign o_rs2_val   = w_rs2[XLEN-1:0];
  assign o_busy_cnt  = r_busy_cnt;

endmodule

// File: tb/tb_reg_rename_file.sv
// Directed self-checking bench for reg_rename_file.
module tb_reg_rename_file;

  logic        clk;
  logic        rst;
  logic        i_rdy;
  logic        i_flush;
  logic        i_issue_en;
  logic [4:0]  i_issue_rd;
  logic [3:0]  i_issue_tag;
  logic        i_commit_en;
  logic [4:0]  i_commit_rd;
  logic [3:0]  i_commit_tag;
  logic [31:0] i_commit_val;
  logic [4:0]  i_rs1_addr;
  logic [4:0]  i_rs2_addr;
  logic        o_rs1_ready;
  logic [31:0] o_rs1_val;
  logic        o_rs2_ready;
  logic [31:0] o_rs2_val;
  logic [5:0]  o_busy_cnt;

  int n_asserts = 0;
  int n_fail    = 0;

  reg_rename_file #(
    .XLEN     (32),
    .ROB_IDX_W(4),
    .NREG     (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_rdy       (i_rdy),
    .i_flush     (i_flush),
    .i_issue_en  (i_issue_en),
    .i_issue_rd  (i_issue_rd),
    .i_issue_tag (i_issue_tag),
    .i_commit_en (i_commit_en),
    .i_commit_rd (i_commit_rd),
    .i_commit_tag(i_commit_tag),
    .i_commit_val(i_commit_val),
    .i_rs1_addr  (i_rs1_addr),
    .i_rs2_addr  (i_rs2_addr),
    .o_rs1_ready (o_rs1_ready),
    .o_rs1_val   (o_rs1_val),
    .o_rs2_ready (o_rs2_ready),
    .o_rs2_val   (o_rs2_val),
    .o_busy_cnt  (o_busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_ports(input logic [4:0] a1, input logic [4:0] a2);
    i_rs1_addr = a1;
    i_rs2_addr = a2;
    #1;
  endtask

  task automatic idle();
    i_issue_en  = 1'b0;
    i_commit_en = 1'b0;
    i_flush     = 1'b0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [3:0] tag);
    i_issue_en  = 1'b1;
    i_issue_rd  = rd;
    i_issue_tag = tag;
  endtask

  task automatic commit(input logic [4:0] rd, input logic [3:0] tag, input logic [31:0] val);
    i_commit_en  = 1'b1;
    i_commit_rd  = rd;
    i_commit_tag = tag;
    i_commit_val = val;
  endtask

  initial begin
    rst          = 1'b1;
    i_rdy        = 1'b1;
    i_flush      = 1'b0;
    i_issue_en   = 1'b0;
    i_issue_rd   = 5'd0;
    i_issue_tag  = 4'd0;
    i_commit_en  = 1'b0;
    i_commit_rd  = 5'd0;
    i_commit_tag = 4'd0;
    i_commit_val = 32'd0;
    i_rs1_addr   = 5'd5;
    i_rs2_addr   = 5'd0;
    step();
    step();
    rd_ports(5'd5, 5'd0);
    check("rst_rs1_ready", 32'(o_rs1_ready), 32'd1);
    check("rst_rs1_val", o_rs1_val, 32'd0);
    check("rst_rs2_ready", 32'(o_rs2_ready), 32'd1);
    check("rst_rs2_val", o_rs2_val, 32'd0);
    check("rst_busy_cnt", 32'(o_busy_cnt), 32'd0);
    rst = 1'b0;

    // Basic issue then matching commit
    issue(5'd5, 4'd3);
    step();
    idle();
    rd_ports(5'd5, 5'd0);
    check("iss_x5_ready", 32'(o_rs1_ready), 32'd0);
    check("iss_x5_tag", o_rs1_val, 32'd3);
    check("iss_cnt", 32'(o_busy_cnt), 32'd1);
    commit(5'd5, 4'd3, 32'hDEADBEEF);
    step();
    idle();
    rd_ports(5'd5, 5'd0);
    check("cmt_x5_ready", 32'(o_rs1_ready), 32'd1);
    check("cmt_x5_val", o_rs1_val, 32'hDEADBEEF);
    check("cmt_cnt", 32'(o_busy_cnt), 32'd0);

    // Stale commit leaves the younger producer pending
    issue(5'd7, 4'd2);
    step();
    issue(5'd7, 4'd9);
    step();
    idle();
    check("x7_cnt", 32'(o_busy_cnt), 32'd1);
    commit(5'd7, 4'd2, 32'h11);
    step();
    idle();
    rd_ports(5'd7, 5'd0);
    check("stale_ready", 32'(o_rs1_ready), 32'd0);
    check("stale_tag", o_rs1_val, 32'd9);
    check("stale_cnt", 32'(o_busy_cnt), 32'd1);
    commit(5'd7, 4'd9, 32'h22);
    step();
    idle();
    rd_ports(5'd7, 5'd0);
    check("young_ready", 32'(o_rs1_ready), 32'd1);
    check("young_val", o_rs1_val, 32'h22);
    check("young_cnt", 32'(o_busy_cnt), 32'd0);

    // Same-cycle commit and issue to x4
    issue(5'd4, 4'd1);
    step();
    commit(5'd4, 4'd1, 32'h55);
    issue(5'd4, 4'd6);
    step();
    idle();
    rd_ports(5'd4, 5'd0);
    check("same_ready", 32'(o_rs1_ready), 32'd0);
    check("same_tag", o_rs1_val, 32'd6);
    check("same_cnt", 32'(o_busy_cnt), 32'd1);

    // Flush with same-cycle issue (dropped) and commit (value kept)
    issue(5'd1, 4'd1);
    step();
    issue(5'd2, 4'd2);
    step();
    issue(5'd3, 4'd3);
    step();
    idle();
    check("pre_flush_cnt", 32'(o_busy_cnt), 32'd4);
    i_flush = 1'b1;
    issue(5'd8, 4'd4);
    commit(5'd2, 4'd0, 32'h77);
    step();
    idle();
    check("flush_cnt", 32'(o_busy_cnt), 32'd0);
    rd_ports(5'd2, 5'd8);
    check("flush_x2_ready", 32'(o_rs1_ready), 32'd1);
    check("flush_x2_val", o_rs1_val, 32'h77);
    check("flush_x8_ready", 32'(o_rs2_ready), 32'd1);
    check("flush_x8_val", o_rs2_val, 32'd0);
    rd_ports(5'd4, 5'd1);
    check("flush_x4_val", o_rs1_val, 32'h55);
    check("flush_x1_ready", 32'(o_rs2_ready), 32'd1);
    check("flush_x1_val", o_rs2_val, 32'd0);

    // x0 is hardwired
    issue(5'd0, 4'd5);
    commit(5'd0, 4'd5, 32'h99);
    step();
    idle();
    rd_ports(5'd0, 5'd0);
    check("x0_ready", 32'(o_rs1_ready), 32'd1);
    check("x0_val", o_rs1_val, 32'd0);
    check("x0_cnt", 32'(o_busy_cnt), 32'd0);

    // rdy low holds all state
    i_rdy = 1'b0;
    issue(5'd9, 4'd7);
    step();
    commit(5'd9, 4'd7, 32'h33);
    step();
    idle();
    i_rdy = 1'b1;
    rd_ports(5'd9, 5'd0);
    check("hold_x9_ready", 32'(o_rs1_ready), 32'd1);
    check("hold_x9_val", o_rs1_val, 32'd0);
    check("hold_cnt", 32'(o_busy_cnt), 32'd0);

    // Same-cycle read of a committing register
    issue(5'd5, 4'd10);
    step();
    idle();
    commit(5'd5, 4'd10, 32'hCAFE0005);
    rd_ports(5'd5, 5'd0);
`ifdef REG_COMMIT_BYPASS_EN
    check("byp_ready", 32'(o_rs1_ready), 32'd1);
    check("byp_val", o_rs1_val, 32'hCAFE0005);
`else
    check("byp_ready", 32'(o_rs1_ready), 32'd0);
    check("byp_val", o_rs1_val, 32'd10);
`endif
    step();
    idle();
    rd_ports(5'd5, 5'd0);
    check("post_byp_ready", 32'(o_rs1_ready), 32'd1);
    check("post_byp_val", o_rs1_val, 32'hCAFE0005);
    check("post_byp_cnt", 32'(o_busy_cnt), 32'd0);

    // Synchronous reset clears values
    rst = 1'b1;
    step();
    rst = 1'b0;
    rd_ports(5'd5, 5'd2);
    check("rst2_x5_val", o_rs1_val, 32'd0);
    check("rst2_x2_val", o_rs2_val, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
